// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV32I opcode, immediate-select, ALU and branch constants.
package riscv_pkg;
    localparam logic [6:0] OP_Rtype      = 7'b0110011;
    localparam logic [6:0] OP_Itype      = 7'b0010011;
    localparam logic [6:0] OP_Itype_load = 7'b0000011;
    localparam logic [6:0] OP_Stype      = 7'b0100011;
    localparam logic [6:0] OP_Btype      = 7'b1100011;
    localparam logic [6:0] OP_JAL        = 7'b1101111;
    localparam logic [6:0] OP_JALR       = 7'b1100111;
    localparam logic [6:0] OP_LUI        = 7'b0110111;
    localparam logic [6:0] OP_AUIPC      = 7'b0010111;
    localparam logic [2:0] I_TYPE = 3'b000;
    localparam logic [2:0] S_TYPE = 3'b001;
    localparam logic [2:0] B_TYPE = 3'b010;
    localparam logic [2:0] J_TYPE = 3'b011;
    localparam logic [2:0] U_TYPE = 3'b100;
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;
endpackage

// File: rtl/imm_gen_unit.sv
// imm_gen_unit: RV32I immediate extraction with a registered copy and illegal-select flag.
module imm_gen_unit
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [31:7]     inst_i,
    input  logic [2:0]      ImmSel_i,
    output logic [XLEN-1:0] imm_o,
    output logic [XLEN-1:0] imm_q_o,
    output logic            sel_err_o
);
    // Shift immediates ride the plain I format; the consumer picks imm[4:0] and imm[10].
    always_comb begin
        imm_o = ImmSel_i == I_TYPE ? {{20{inst_i[31]}}, inst_i[31:20]} :
                ImmSel_i == S_TYPE ? {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]} :
                ImmSel_i == B_TYPE ? {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0} :
                ImmSel_i == J_TYPE ? {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0} :
                ImmSel_i == U_TYPE ? {inst_i[31:12], 12'b0} : '0;
        sel_err_o = ImmSel_i > U_TYPE;
    end
    always_ff @(posedge clk_i)
        imm_q_o <= rst_i ? '0 : imm_o;
endmodule

// File: tb/tb_imm_gen_unit.sv
// tb_imm_gen_unit: directed test-plan vectors plus random instructions against an arithmetic model.
module tb_imm_gen_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] ins = '0;
    logic [2:0]  sel = '0;
    logic [31:0] imm, imm_q;
    logic        err;
    int          total = 0, bad = 0;

    imm_gen_unit dut (
        .clk_i(clk), .rst_i(rst), .inst_i(ins[31:7]), .ImmSel_i(sel),
        .imm_o(imm), .imm_q_o(imm_q), .sel_err_o(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Field weights computed arithmetically: sign comes from an arithmetic shift of bit 31.
    function automatic logic [31:0] ref_imm(input logic [31:0] i, input logic [2:0] s);
        int sx = $signed(i);
        int neg = sx >>> 31;
        case (s)
            3'd0: return sx >>> 20;
            3'd1: return (sx >>> 25) * 32 + ((i >> 7) & 31);
            3'd2: return neg * 4096 + ((i >> 7) & 1) * 2048 + ((i >> 25) & 63) * 32 + ((i >> 8) & 15) * 2;
            3'd3: return neg * (1 << 20) + ((i >> 12) & 255) * 4096 + ((i >> 20) & 1) * 2048 + ((i >> 21) & 1023) * 2;
            3'd4: return i & 32'hFFFFF000;
            default: return 32'h0;
        endcase
    endfunction

    task automatic apply(input string tag, input logic [31:0] i, input logic [2:0] s,
                         input logic r, input logic [31:0] e);
        @(negedge clk);
        ins = i; sel = s; rst = r;
        #1;
        check(tag, imm, e);
        check({tag, "_err"}, {31'b0, err}, {31'b0, s > 3'd4});
        @(posedge clk);
        #1;
        check({tag, "_q"}, imm_q, r ? 32'h0 : e);
    endtask

    initial begin
        @(posedge clk);
        #1;
        check("reset_q", imm_q, 32'h0);
        apply("lui",   32'h000042B7, 3'd4, 1'b0, 32'h00004000);
        apply("auipc", 32'h0000B317, 3'd4, 1'b0, 32'h0000B000);
        apply("jal",   32'h0080056F, 3'd3, 1'b0, 32'h00000008);
        apply("jalr",  32'h00C301E7, 3'd0, 1'b0, 32'h0000000C);
        apply("addi",  32'hFFB88D13, 3'd0, 1'b0, 32'hFFFFFFFB);
        apply("andi",  32'hFFD4F293, 3'd0, 1'b0, 32'hFFFFFFFD);
        apply("beq",   32'h013A0663, 3'd2, 1'b0, 32'h0000000C);
        apply("bne",   32'h013A1563, 3'd2, 1'b0, 32'h0000000A);
        apply("bgeu",  32'h0107F863, 3'd2, 1'b0, 32'h00000010);
        apply("bneg",  32'hFE000EE3, 3'd2, 1'b0, 32'hFFFFFFFC);
        apply("sb",    32'h02678223, 3'd1, 1'b0, 32'h00000024);
        apply("sw",    32'h00912223, 3'd1, 1'b0, 32'h00000004);
        apply("sh",    32'hFE001623, 3'd1, 1'b0, 32'hFFFFFFEC);
        apply("ill7",  32'h005505B3, 3'd7, 1'b0, 32'h0);
        apply("ill5",  32'h005505B3, 3'd5, 1'b0, 32'h0);
        apply("ill6",  32'h005505B3, 3'd6, 1'b0, 32'h0);
        apply("srai",  32'h40355293, 3'd0, 1'b0, 32'h00000403);
        apply("rst_mid", 32'h000042B7, 3'd4, 1'b1, 32'h00004000);
        apply("lui2",  32'h000042B7, 3'd4, 1'b0, 32'h00004000);
        for (int n = 0; n < 300; n++) begin
            logic [31:0] ri = $urandom;
            logic [2:0]  rs = 3'($urandom_range(0, 7));
            apply("rand", ri, rs, ($urandom_range(0, 15) == 0), ref_imm(ri, rs));
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
